proc_frame_sequencer: RTL and testbench

Control block in the processor (clk) domain that runs frame jobs through the producer -> async FIFO -> data_proc pipeline. It accepts a command (mode, frame count), configures and starts data_proc, gates producer pixel flow, and counts accepted output pixels per frame. Between frames it drains the FIFO and pulses a subsystem reset, so every frame starts from pixel 0 with clean pipeline state.

---
 rtl/proc_frame_sequencer_if.sv | 33 +++
 rtl/proc_frame_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_proc_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_frame_sequencer_if.sv
// Command, pipeline-control and status signals of the frame sequencer.
// The sequencer uses the slave modport; whoever issues commands and
// reports pipeline status (top-level glue or a bench) uses master.
interface proc_frame_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_frames;
  logic       abort;
  logic [1:0] proc_mode;
  logic       proc_start;
  logic       prod_enable;
  logic       sub_rst_n;
  logic       out_fire;
  logic       fifo_empty;
  logic       busy;
  logic       frame_done;
  logic [7:0] frames_left;
  logic       err;
  logic [1:0] err_code;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_frames, abort, out_fire, fifo_empty,
    output cmd_ready, proc_mode, proc_start, prod_enable, sub_rst_n,
           busy, frame_done, frames_left, err, err_code
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_frames, abort, out_fire, fifo_empty,
    input  cmd_ready, proc_mode, proc_start, prod_enable, sub_rst_n,
           busy, frame_done, frames_left, err, err_code
  );
endinterface

// File: rtl/proc_frame_sequencer.sv
// Frame-job sequencer for the producer -> async FIFO -> data_proc pipeline.
// Runs a job of N frames: start data_proc, let pixels flow, count output
// pixels, then drain the FIFO and reset the subsystem between frames.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a command; cmd_ready high
// ST_ARM    | proc_start high, producer still gated for ARM_CYCLES
// ST_RUN    | pixels flowing; counting out_fire, watching for stalls
// ST_DRAIN  | producer gated; wait for fifo_empty or DRAIN_MAX cycles
// ST_RESET  | sub_rst_n low for RST_CYCLES; pixel counter cleared
// ST_SETTLE | sub_rst_n released; wait SETTLE_CYCLES, then next frame/IDLE
module proc_frame_sequencer #(
  parameter int FRAME_PIXELS  = 1024,
  parameter int CNT_W         = 11,
  parameter int ARM_CYCLES    = 5,
  parameter int DRAIN_MAX     = 100,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 10,
  parameter int TIMEOUT       = 65535
) (
  input  logic                  clk,
  input  logic                  resetn,
  proc_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESET  = 3'd4,
    ST_SETTLE = 3'd5
  } state_t;

  localparam int TMR_W = 16;
  // Phase timers count down from N-1 so that the terminal-count cycle is
  // the N-th cycle spent in the phase.
  localparam logic [TMR_W-1:0] ARM_LOAD    = TMR_W'(ARM_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_MAX - 1);
  localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      IDLE_LOAD   = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAST_PIX    = CNT_W'(FRAME_PIXELS - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      idle_q, idle_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             cancel_q, cancel_d;
  logic [7:0]       frames_left_q, frames_left_d;
  logic [1:0]       proc_mode_q, proc_mode_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_q, err_d;
  logic             frame_done_q, frame_done_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             proc_start_q, proc_start_d;
  logic             prod_enable_q, prod_enable_d;
  logic             sub_rst_n_q, sub_rst_n_d;
  logic             busy_q, busy_d;

  // State register and all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      idle_q        <= '0;
      pix_cnt_q     <= '0;
      cancel_q      <= 1'b0;
      frames_left_q <= '0;
      proc_mode_q   <= '0;
      err_code_q    <= '0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      cmd_ready_q   <= 1'b0;
      proc_start_q  <= 1'b0;
      prod_enable_q <= 1'b0;
      sub_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      idle_q        <= idle_d;
      pix_cnt_q     <= pix_cnt_d;
      cancel_q      <= cancel_d;
      frames_left_q <= frames_left_d;
      proc_mode_q   <= proc_mode_d;
      err_code_q    <= err_code_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
      cmd_ready_q   <= cmd_ready_d;
      proc_start_q  <= proc_start_d;
      prod_enable_q <= prod_enable_d;
      sub_rst_n_q   <= sub_rst_n_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, counters, and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    idle_d        = idle_q;
    pix_cnt_d     = pix_cnt_q;
    cancel_d      = cancel_q;
    frames_left_d = frames_left_q;
    proc_mode_d   = proc_mode_q;
    err_code_d    = err_code_q;
    err_d         = 1'b0;
    frame_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_mode == 2'b11) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (bus.cmd_frames == 8'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end else begin
            proc_mode_d   = bus.cmd_mode;
            frames_left_d = bus.cmd_frames;
            err_code_d    = 2'b00;
            cancel_d      = 1'b0;
            state_d       = ST_ARM;
          end
        end
      end

      ST_ARM: begin
        if (bus.abort) begin
          cancel_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_RUN: begin
        // A final-pixel fire still completes the frame even if abort is
        // raised in the same cycle; a fire always beats the stall timeout.
        if (bus.out_fire && (pix_cnt_q == LAST_PIX)) begin
          pix_cnt_d    = pix_cnt_q + 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_DRAIN;
          if (bus.abort) begin
            cancel_d = 1'b1;
          end
        end else if (bus.abort) begin
          cancel_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (bus.out_fire) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          idle_d    = IDLE_LOAD;
        end else if (idle_q == '0) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          cancel_d   = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          idle_d = idle_q - 1'b1;
        end
      end

      ST_DRAIN: begin
        if (bus.fifo_empty || (tmr_q == '0)) begin
          state_d = ST_RESET;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_RESET: begin
        pix_cnt_d = '0;
        if (tmr_q == '0) begin
          state_d = ST_SETTLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (tmr_q == '0) begin
          if ((frames_left_q > 8'd1) && !cancel_q) begin
            frames_left_d = frames_left_q - 8'd1;
            state_d       = ST_ARM;
          end else begin
            frames_left_d = 8'd0;
            state_d       = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      case (state_d)
        ST_ARM:    tmr_d = ARM_LOAD;
        ST_DRAIN:  tmr_d = DRAIN_LOAD;
        ST_RESET:  tmr_d = RST_LOAD;
        ST_SETTLE: tmr_d = SETTLE_LOAD;
        default:   tmr_d = '0;
      endcase
    end

    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      idle_d = IDLE_LOAD;
    end

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_d   = (state_d == ST_IDLE);
    proc_start_d  = (state_d == ST_ARM) || (state_d == ST_RUN);
    prod_enable_d = (state_d == ST_RUN);
    sub_rst_n_d   = (state_d != ST_RESET);
    busy_d        = (state_d != ST_IDLE);
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.proc_mode   = proc_mode_q;
  assign bus.proc_start  = proc_start_q;
  assign bus.prod_enable = prod_enable_q;
  assign bus.sub_rst_n   = sub_rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frames_left = frames_left_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_proc_frame_sequencer.sv
// Directed bench for proc_frame_sequencer; stall timeout shortened to 50.
module tb_proc_frame_sequencer;
  logic clk = 1'b0;
  logic resetn;
  int   n_pass  = 0;
  int   n_total = 0;

  proc_frame_sequencer_if bus ();

  proc_frame_sequencer #(.TIMEOUT(50)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One clock; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [7:0] frames);
    bus.cmd_mode   = mode;
    bus.cmd_frames = frames;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic run_to_idle(input int max_cyc, output int cyc, output int n_done, output int n_err);
    cyc = 0; n_done = 0; n_err = 0;
    while (bus.busy === 1'b1 && cyc < max_cyc) begin
      tick();
      cyc++;
      if (bus.frame_done === 1'b1) n_done++;
      if (bus.err === 1'b1) n_err++;
    end
  endtask

  function automatic logic [18:0] outs();
    return {bus.cmd_ready, bus.proc_mode, bus.proc_start, bus.prod_enable, bus.sub_rst_n,
            bus.busy, bus.frame_done, bus.frames_left, bus.err, bus.err_code};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_total++;
    if (outs() !== 19'd0) $display("FAIL reset_outputs: got %h expected %h", outs(), 19'd0);
    else n_pass++;
    resetn = 1'b1;
    tick();
    n_total++;
    if ({bus.cmd_ready, bus.sub_rst_n, bus.busy} !== 3'b110)
      $display("FAIL reset_release: got %b expected 110", {bus.cmd_ready, bus.sub_rst_n, bus.busy});
    else n_pass++;
  endtask

  task automatic test_single_frame();
    int done_at, lo, st;
    logic pe_early;
    bus.out_fire = 1'b1; bus.fifo_empty = 1'b1;
    send_cmd(2'b01, 8'd1);
    n_total++;
    if ({bus.proc_start, bus.prod_enable, bus.busy, bus.frames_left} !== {3'b101, 8'd1})
      $display("FAIL sf_arm_entry: got %h expected %h",
               {bus.proc_start, bus.prod_enable, bus.busy, bus.frames_left}, {3'b101, 8'd1});
    else n_pass++;
    pe_early = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      if (bus.prod_enable !== 1'b0) pe_early = 1'b1;
    end
    n_total++;
    if (pe_early !== 1'b0) $display("FAIL sf_prod_enable_early: got 1 expected 0");
    else n_pass++;
    tick();
    n_total++;
    if (bus.prod_enable !== 1'b1) $display("FAIL sf_prod_enable_rise: got %b expected 1", bus.prod_enable);
    else n_pass++;
    done_at = -1;
    for (int n = 1; n <= 1100; n++) begin
      tick();
      if (bus.frame_done === 1'b1) begin done_at = n; break; end
    end
    n_total++;
    if (done_at !== 1024) $display("FAIL sf_frame_done_at: got %0d expected 1024", done_at);
    else n_pass++;
    n_total++;
    if ({bus.prod_enable, bus.proc_start} !== 2'b00)
      $display("FAIL sf_drain_gating: got %b expected 00", {bus.prod_enable, bus.proc_start});
    else n_pass++;
    lo = 0;
    tick();
    while (bus.sub_rst_n === 1'b0 && lo < 50) begin lo++; tick(); end
    n_total++;
    if (lo !== 8) $display("FAIL sf_sub_rst_low: got %0d expected 8", lo);
    else n_pass++;
    st = 0;
    while (bus.busy === 1'b1 && st < 50) begin st++; tick(); end
    n_total++;
    if (st !== 10) $display("FAIL sf_settle_len: got %0d expected 10", st);
    else n_pass++;
    n_total++;
    if ({bus.busy, bus.cmd_ready, bus.frames_left, bus.proc_mode} !== {2'b01, 8'd0, 2'b01})
      $display("FAIL sf_idle: got %h expected %h",
               {bus.busy, bus.cmd_ready, bus.frames_left, bus.proc_mode}, {2'b01, 8'd0, 2'b01});
    else n_pass++;
  endtask

  task automatic test_multi_frame();
    int n_done, arm_re, cyc, rise_at;
    int fl_seen[3];
    int len[3];
    logic prev_ps, prev_pe;
    int exp_fl;
    bus.out_fire = 1'b1; bus.fifo_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin fl_seen[i] = -1; len[i] = -1; end
    n_done = 0; arm_re = 0; cyc = 0; rise_at = 0;
    send_cmd(2'b10, 8'd3);
    prev_ps = bus.proc_start; prev_pe = bus.prod_enable;
    while (bus.busy === 1'b1 && cyc < 8000) begin
      tick();
      cyc++;
      if (prev_ps === 1'b0 && bus.proc_start === 1'b1) arm_re++;
      if (prev_pe === 1'b0 && bus.prod_enable === 1'b1) rise_at = cyc;
      prev_ps = bus.proc_start; prev_pe = bus.prod_enable;
      if (bus.frame_done === 1'b1) begin
        if (n_done < 3) begin fl_seen[n_done] = int'(bus.frames_left); len[n_done] = cyc - rise_at; end
        n_done++;
      end
    end
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL mf_reach_idle: got busy=%b expected 0", bus.busy);
    else n_pass++;
    n_total++;
    if (n_done !== 3) $display("FAIL mf_done_count: got %0d expected 3", n_done);
    else n_pass++;
    n_total++;
    if (arm_re !== 2) $display("FAIL mf_arm_reentry: got %0d expected 2", arm_re);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp_fl = 3 - i;
      n_total++;
      if (fl_seen[i] !== exp_fl) $display("FAIL mf_frames_left_%0d: got %0d expected %0d", i, fl_seen[i], exp_fl);
      else n_pass++;
      n_total++;
      if (len[i] !== 1024) $display("FAIL mf_frame_len_%0d: got %0d expected 1024", i, len[i]);
      else n_pass++;
    end
    n_total++;
    if ({bus.frames_left, bus.proc_mode} !== {8'd0, 2'b10})
      $display("FAIL mf_final: got %h expected %h", {bus.frames_left, bus.proc_mode}, {8'd0, 2'b10});
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic act_seen;
    send_cmd(2'b11, 8'd5);
    n_total++;
    if ({bus.err, bus.err_code, bus.busy, bus.cmd_ready, bus.proc_mode} !== 7'b1_01_0_1_10)
      $display("FAIL il_mode11: got %b expected 1010110",
               {bus.err, bus.err_code, bus.busy, bus.cmd_ready, bus.proc_mode});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.err, bus.err_code} !== 3'b0_01)
      $display("FAIL il_err_pulse_hold: got %b expected 001", {bus.err, bus.err_code});
    else n_pass++;
    send_cmd(2'b00, 8'd0);
    n_total++;
    if ({bus.err, bus.err_code, bus.busy} !== 4'b1_11_0)
      $display("FAIL il_zero_frames: got %b expected 1110", {bus.err, bus.err_code, bus.busy});
    else n_pass++;
    act_seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.prod_enable !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) act_seen = 1'b1;
    end
    n_total++;
    if (act_seen !== 1'b0 || bus.err_code !== 2'b11)
      $display("FAIL il_quiet: got activity=%b err_code=%b expected 0 and 11", act_seen, bus.err_code);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int err_at, cyc, n_done, n_err;
    bus.out_fire = 1'b0; bus.fifo_empty = 1'b1;
    send_cmd(2'b00, 8'd2);
    err_at = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (bus.err === 1'b1) begin err_at = k; break; end
    end
    n_total++;
    if (err_at !== 55) $display("FAIL to_err_at: got %0d expected 55", err_at);
    else n_pass++;
    n_total++;
    if ({bus.err_code, bus.prod_enable, bus.frame_done} !== 4'b10_0_0)
      $display("FAIL to_state: got %b expected 1000", {bus.err_code, bus.prod_enable, bus.frame_done});
    else n_pass++;
    run_to_idle(100, cyc, n_done, n_err);
    n_total++;
    if ({bus.busy, bus.frames_left, bus.err_code} !== {1'b0, 8'd0, 2'b10} || n_done !== 0 || n_err !== 0)
      $display("FAIL to_finish: got busy=%b frames_left=%0d err_code=%b done=%0d errs=%0d expected 0 0 10 0 0",
               bus.busy, bus.frames_left, bus.err_code, n_done, n_err);
    else n_pass++;
  endtask

  task automatic test_drain_limit();
    int dr, cyc, n_done, n_err;
    bus.out_fire = 1'b0; bus.fifo_empty = 1'b0;
    send_cmd(2'b01, 8'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_total++;
    if ({bus.proc_start, bus.prod_enable, bus.sub_rst_n, bus.busy} !== 4'b0011)
      $display("FAIL dl_abort_arm: got %b expected 0011",
               {bus.proc_start, bus.prod_enable, bus.sub_rst_n, bus.busy});
    else n_pass++;
    dr = 0;
    while (bus.sub_rst_n === 1'b1 && dr < 300) begin dr++; tick(); end
    n_total++;
    if (dr !== 100) $display("FAIL dl_drain_max: got %0d expected 100", dr);
    else n_pass++;
    bus.fifo_empty = 1'b1;
    run_to_idle(100, cyc, n_done, n_err);
    n_total++;
    if ({bus.busy, bus.frames_left, bus.err_code} !== 11'd0 || n_done !== 0 || n_err !== 0)
      $display("FAIL dl_finish: got busy=%b frames_left=%0d err_code=%b done=%0d errs=%0d expected all 0",
               bus.busy, bus.frames_left, bus.err_code, n_done, n_err);
    else n_pass++;
    bus.fifo_empty = 1'b0;
    send_cmd(2'b01, 8'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    tick();
    bus.fifo_empty = 1'b1;
    n_total++;
    if (bus.sub_rst_n !== 1'b1) $display("FAIL dl_third_drain: got sub_rst_n=%b expected 1", bus.sub_rst_n);
    else n_pass++;
    tick();
    n_total++;
    if (bus.sub_rst_n !== 1'b0) $display("FAIL dl_empty_exit: got sub_rst_n=%b expected 0", bus.sub_rst_n);
    else n_pass++;
    run_to_idle(100, cyc, n_done, n_err);
  endtask

  task automatic test_abort();
    int cyc, n_done, n_err;
    bus.out_fire = 1'b1; bus.fifo_empty = 1'b1;
    send_cmd(2'b01, 8'd4);
    repeat (5) tick();
    n_total++;
    if (bus.prod_enable !== 1'b1) $display("FAIL ab_run: got prod_enable=%b expected 1", bus.prod_enable);
    else n_pass++;
    repeat (500) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_total++;
    if ({bus.prod_enable, bus.frame_done, bus.frames_left} !== {2'b00, 8'd4})
      $display("FAIL ab_fall: got %h expected %h", {bus.prod_enable, bus.frame_done, bus.frames_left}, {2'b00, 8'd4});
    else n_pass++;
    run_to_idle(100, cyc, n_done, n_err);
    n_total++;
    if ({bus.busy, bus.frames_left} !== 9'd0 || n_done !== 0 || n_err !== 0)
      $display("FAIL ab_finish: got busy=%b frames_left=%0d done=%0d errs=%0d expected all 0",
               bus.busy, bus.frames_left, n_done, n_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bus.out_fire = 1'b1; bus.fifo_empty = 1'b1;
    send_cmd(2'b01, 8'd4);
    repeat (20) tick();
    n_total++;
    if (bus.prod_enable !== 1'b1) $display("FAIL rr_running: got prod_enable=%b expected 1", bus.prod_enable);
    else n_pass++;
    resetn = 1'b0;
    tick();
    n_total++;
    if (outs() !== 19'd0) $display("FAIL rr_outputs: got %h expected %h", outs(), 19'd0);
    else n_pass++;
    resetn = 1'b1;
    tick();
    n_total++;
    if ({bus.cmd_ready, bus.sub_rst_n, bus.busy} !== 3'b110)
      $display("FAIL rr_release: got %b expected 110", {bus.cmd_ready, bus.sub_rst_n, bus.busy});
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 2'b00; bus.cmd_frames = 8'd0;
    bus.abort = 1'b0; bus.out_fire = 1'b0; bus.fifo_empty = 1'b1;
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_illegal();
    test_timeout();
    test_drain_limit();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
